// File: rtl/mac_sequencer.sv
// Beat sequencer for the SIMD MAC: issues operand beats, tracks them through
// the adder-tree latency, accumulates sums and emits a scaled, saturated result.
module mac_sequencer #(
    parameter int SUM_WIDTH    = 38,
    parameter int TREE_LATENCY = 3,
    parameter int MAX_BEATS    = 256,
    parameter int MAX_OUTPUTS  = 65535,
    parameter int ACC_WIDTH    = SUM_WIDTH + $clog2(MAX_BEATS),
    parameter int OUTPUT_WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               rst_in,
    input  logic                               start_in,
    input  logic [$clog2(MAX_BEATS+1)-1:0]     num_beats_in,
    input  logic [$clog2(MAX_OUTPUTS+1)-1:0]   num_outputs_in,
    input  logic [5:0]                         scale_in,
    output logic                               busy_out,
    output logic                               done_out,
    input  logic                               fetch_valid_in,
    output logic                               fetch_ready_out,
    output logic                               mac_valid_out,
    input  logic [SUM_WIDTH-1:0]               mac_sum_in,
    output logic                               out_valid_out,
    input  logic                               out_ready_in,
    output logic [OUTPUT_WIDTH-1:0]            out_data_out
);

    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam int OCW = $clog2(MAX_OUTPUTS + 1);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUTPUT
    } state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [BW-1:0]                r_nbeats;
    logic [OCW-1:0]               r_nouts;
    logic [5:0]                   r_scale;
    logic [BW-1:0]                r_beat_cnt;
    logic [OCW-1:0]               r_out_cnt;
    logic [TREE_LATENCY-1:0]      r_vpipe;
    logic [TREE_LATENCY-1:0]      w_vpipe_nx;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic signed [ACC_WIDTH-1:0]  w_sum_ext;
    logic signed [ACC_WIDTH-1:0]  w_shifted;
    logic [OUTPUT_WIDTH-1:0]      w_sat;
    logic                         r_done;

    logic w_issue;
    logic w_load;
    logic w_clr;
    logic w_done_set;
    logic w_next_out;

    assign w_sum_ext = {{(ACC_WIDTH-SUM_WIDTH){mac_sum_in[SUM_WIDTH-1]}},
                        mac_sum_in};

    // Next-state and per-cycle control decode
    always_comb begin
        w_next     = r_state;
        w_issue    = 1'b0;
        w_load     = 1'b0;
        w_clr      = 1'b0;
        w_done_set = 1'b0;
        w_next_out = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start_in) begin
                    w_load = 1'b1;
                    if (num_outputs_in == '0) begin
                        w_done_set = 1'b1;
                    end else begin
                        w_clr  = 1'b1;
                        w_next = (num_beats_in == '0) ? S_DRAIN : S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                w_issue = fetch_valid_in;
                if (w_issue && (r_beat_cnt == r_nbeats - BW'(1))) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_vpipe == '0) begin
                    w_next = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (out_ready_in) begin
                    if (r_out_cnt == r_nouts - OCW'(1)) begin
                        w_done_set = 1'b1;
                        w_next     = S_IDLE;
                    end else begin
                        w_clr      = 1'b1;
                        w_next_out = 1'b1;
                        w_next     = (r_nbeats == '0) ? S_DRAIN : S_ISSUE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Valid pipe shifts every cycle; bit 0 takes this cycle's issue
    always_comb begin
        w_vpipe_nx    = r_vpipe << 1;
        w_vpipe_nx[0] = w_issue;
    end

    // State, configuration, counters, valid pipe and done pulse
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_nbeats   <= '0;
            r_nouts    <= '0;
            r_scale    <= '0;
            r_beat_cnt <= '0;
            r_out_cnt  <= '0;
            r_vpipe    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_vpipe <= w_vpipe_nx;
            r_done  <= w_done_set;
            if (w_load) begin
                r_nbeats  <= num_beats_in;
                r_nouts   <= num_outputs_in;
                r_scale   <= scale_in;
                r_out_cnt <= '0;
            end else if (w_next_out) begin
                r_out_cnt <= r_out_cnt + OCW'(1);
            end
            if (w_clr) begin
                r_beat_cnt <= '0;
            end else if (w_issue) begin
                r_beat_cnt <= r_beat_cnt + BW'(1);
            end
        end
    end

    // Accumulate tree sums whose beat reaches the end of the valid pipe
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_acc <= '0;
        end else if (w_clr) begin
            r_acc <= '0;
        end else if (r_vpipe[TREE_LATENCY-1]) begin
            r_acc <= r_acc + w_sum_ext;
        end
    end

    // Scale and saturate the held accumulator into the result range
    always_comb begin
        w_shifted = r_acc >>> r_scale;
        if (w_shifted > SAT_MAX) begin
            w_sat = SAT_MAX[OUTPUT_WIDTH-1:0];
        end else if (w_shifted < SAT_MIN) begin
            w_sat = SAT_MIN[OUTPUT_WIDTH-1:0];
        end else begin
            w_sat = w_shifted[OUTPUT_WIDTH-1:0];
        end
    end

    assign busy_out        = (r_state != S_IDLE);
    assign done_out        = r_done;
    assign fetch_ready_out = w_issue;
    assign mac_valid_out   = w_issue;
    assign out_valid_out   = (r_state == S_OUTPUT);
    assign out_data_out    = (r_state == S_OUTPUT) ? w_sat : '0;

endmodule
